// File: rtl/systolic_skew_feeder_4_if.sv
// Row-vector input bus of the systolic skew feeder: valid/ready handshake with last marker.
interface systolic_skew_feeder_4_if #(
   parameter int unsigned DATA_WIDTH = 32
);
   localparam int unsigned LANES = 4;

   logic                          skew_in_valid;
   logic                          skew_in_ready;
   logic                          skew_in_last;
   logic [LANES*DATA_WIDTH-1:0]   skew_in_data;

   modport master (
      output skew_in_valid,
      output skew_in_last,
      output skew_in_data,
      input  skew_in_ready
   );

   modport slave (
      input  skew_in_valid,
      input  skew_in_last,
      input  skew_in_data,
      output skew_in_ready
   );
endinterface

// File: rtl/systolic_skew_feeder_4.sv
// Left-edge skew feeder for a 4x4 systolic array: lane k reaches row k k cycles after lane 0.
// Optional hold-everything stall input enabled by defining SKEW_FEEDER_STALL_EN.
module systolic_skew_feeder_4 #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned CNT_WIDTH  = 8
) (
   input  logic                    skew_clk,
   input  logic                    skew_rst,
`ifdef SKEW_FEEDER_STALL_EN
   input  logic                    skew_stall,
`endif
   systolic_skew_feeder_4_if.slave skew,
   output logic                    skew_en_left_0,
   output logic                    skew_en_left_1,
   output logic                    skew_en_left_2,
   output logic                    skew_en_left_3,
   output logic [DATA_WIDTH-1:0]   skew_data_left_0,
   output logic [DATA_WIDTH-1:0]   skew_data_left_1,
   output logic [DATA_WIDTH-1:0]   skew_data_left_2,
   output logic [DATA_WIDTH-1:0]   skew_data_left_3,
   output logic                    skew_busy,
   output logic                    skew_done,
   output logic [CNT_WIDTH-1:0]    skew_beat_cnt
);

   localparam int unsigned LANES   = 4;
   localparam int unsigned DRAIN_W = 2;
   localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(LANES - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FEED  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t               state;
   logic [DRAIN_W-1:0]   drain_cnt;
   logic                 stall;
   logic                 accept;
   logic                 en_row   [LANES];
   logic [DATA_WIDTH-1:0] data_row [LANES];

`ifdef SKEW_FEEDER_STALL_EN
   assign stall = skew_stall;
`else
   assign stall = 1'b0;
`endif

   // Ready depends only on state and stall, never on valid.
   assign skew.skew_in_ready = (state != DRAIN) && !stall;
   assign accept             = skew.skew_in_valid && skew.skew_in_ready;
   assign skew_busy          = (state != IDLE);

   // Burst control: count beats, then drain the deepest delay line before signalling done.
   always_ff @(posedge skew_clk) begin
      if (skew_rst) begin
         state         <= IDLE;
         drain_cnt     <= '0;
         skew_beat_cnt <= '0;
         skew_done     <= 1'b0;
      end else if (stall) begin
         skew_done     <= 1'b0;
      end else begin
         skew_done <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  skew_beat_cnt <= CNT_WIDTH'(1);
                  if (skew.skew_in_last) begin
                     state     <= DRAIN;
                     drain_cnt <= DRAIN_LOAD;
                  end else begin
                     state     <= FEED;
                  end
               end
            end
            FEED: begin
               if (accept) begin
                  skew_beat_cnt <= skew_beat_cnt + CNT_WIDTH'(1);
                  if (skew.skew_in_last) begin
                     state     <= DRAIN;
                     drain_cnt <= DRAIN_LOAD;
                  end
               end
            end
            DRAIN: begin
               drain_cnt <= drain_cnt - DRAIN_W'(1);
               if (drain_cnt == DRAIN_W'(1)) begin
                  state     <= IDLE;
                  skew_done <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Per-lane delay lines; lane k is k+1 registers deep and zero-filled on bubbles.
   for (genvar k = 0; k < LANES; k++) begin : g_lane
      logic [DATA_WIDTH-1:0]      lane_in;
      logic [k:0]                 en_sr;
      logic [k:0][DATA_WIDTH-1:0] data_sr;

      assign lane_in = accept ? skew.skew_in_data[k*DATA_WIDTH +: DATA_WIDTH] : '0;

      if (k == 0) begin : g_first
         always_ff @(posedge skew_clk) begin
            if (skew_rst) begin
               en_sr   <= '0;
               data_sr <= '0;
            end else if (!stall) begin
               en_sr   <= accept;
               data_sr <= lane_in;
            end
         end
      end else begin : g_deep
         always_ff @(posedge skew_clk) begin
            if (skew_rst) begin
               en_sr   <= '0;
               data_sr <= '0;
            end else if (!stall) begin
               en_sr   <= {en_sr[k-1:0], accept};
               data_sr <= {data_sr[k-1:0], lane_in};
            end
         end
      end

      assign en_row[k]   = en_sr[k];
      assign data_row[k] = data_sr[k];
   end

   assign skew_en_left_0   = en_row[0];
   assign skew_en_left_1   = en_row[1];
   assign skew_en_left_2   = en_row[2];
   assign skew_en_left_3   = en_row[3];
   assign skew_data_left_0 = data_row[0];
   assign skew_data_left_1 = data_row[1];
   assign skew_data_left_2 = data_row[2];
   assign skew_data_left_3 = data_row[3];

endmodule
